// File: rtl/dadda_seq_mul_if.sv
// ---------------------------------------------------------------------------
// dadda_seq_mul_if
//   Operand/result handshake bundle for dadda_seq_mul.
//   W = 8*LIMBS.
//   in_valid  / in_ready  : operand pair handshake (in_a, in_b, each W bits)
//   out_valid / out_ready : result handshake (out_prod, 2W bits)
//   busy                  : multiplier is in MUL or DONE
//   master : operand source / result sink side
//   slave  : multiplier side
// ---------------------------------------------------------------------------
interface dadda_seq_mul_if #(
  parameter int LIMBS = 2
);
  localparam int W = 8 * LIMBS;

  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_prod;
  logic           busy;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_prod, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_prod, busy
  );
endinterface

// File: rtl/dadda_seq_mul.sv
// ---------------------------------------------------------------------------
// dadda_seq_mul
//   Multi-cycle unsigned WxW multiplier, W = 8*LIMBS. One 8x8->16 Dadda
//   limb multiplier is time-shared over all LIMBS*LIMBS limb pairs; the
//   shifted partial products are accumulated into a 2W-bit result.
//   Ports:
//     clk  : clock, all state on the rising edge
//     rst  : synchronous, active-high reset
//     bus  : dadda_seq_mul_if.slave (operand handshake, result handshake,
//            busy status)
//   Flow: IDLE -(accept)-> MUL (LIMBS*LIMBS cycles) -> DONE -(handshake)->
//   IDLE. A zero operand skips MUL and goes straight to DONE with 0.
// ---------------------------------------------------------------------------
module dadda_seq_mul #(
  parameter int LIMBS = 2
) (
  input  logic            clk,
  input  logic            rst,
  dadda_seq_mul_if.slave  bus
);

  localparam int W     = 8 * LIMBS;
  localparam int ACC_W = 2 * W;
  localparam int IW    = (LIMBS > 1) ? $clog2(LIMBS) : 1;
  localparam logic [IW-1:0] LAST = IW'(LIMBS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // -------------------------------------------------------------------------
  // 8x8 unsigned Dadda multiplier. Partial-product bits are held per column;
  // each stage reduces every column to the Dadda target height (6,4,3,2)
  // with half/full adders, counting carries already received from the
  // column to the right. The final two rows are added by a carry-propagate
  // adder. All loop bounds are constant, so this unrolls to a fixed tree.
  // -------------------------------------------------------------------------
  function automatic logic [15:0] dadda_8x8(input logic [7:0] x,
                                            input logic [7:0] y);
    logic        col [17][16];
    logic        nxt [17][16];
    int          h   [17];
    int          nh  [17];
    int          tgt [4];
    int          p;
    int          tot;
    logic        fa_a, fa_b, fa_c;
    logic [15:0] r0;
    logic [15:0] r1;

    tgt = '{6, 4, 3, 2};
    for (int c = 0; c < 17; c++) begin
      h[c]  = 0;
      nh[c] = 0;
      for (int k = 0; k < 16; k++) begin
        col[c][k] = 1'b0;
        nxt[c][k] = 1'b0;
      end
    end

    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        col[i+j][h[i+j]] = x[i] & y[j];
        h[i+j]++;
      end
    end

    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 17; c++) begin
        nh[c] = 0;
        for (int k = 0; k < 16; k++) nxt[c][k] = 1'b0;
      end
      for (int c = 0; c < 16; c++) begin
        p   = 0;
        tot = h[c] + nh[c];  // nh[c] already holds carries from column c-1
        for (int k = 0; k < 4; k++) begin
          if (tot > tgt[s]) begin
            if (tot == tgt[s] + 1) begin
              fa_a = col[c][p];
              fa_b = col[c][p+1];
              nxt[c][nh[c]]     = fa_a ^ fa_b;
              nxt[c+1][nh[c+1]] = fa_a & fa_b;
              nh[c]++;
              nh[c+1]++;
              p   += 2;
              tot -= 1;
            end else begin
              fa_a = col[c][p];
              fa_b = col[c][p+1];
              fa_c = col[c][p+2];
              nxt[c][nh[c]]     = fa_a ^ fa_b ^ fa_c;
              nxt[c+1][nh[c+1]] = (fa_a & fa_b) | (fa_c & (fa_a ^ fa_b));
              nh[c]++;
              nh[c+1]++;
              p   += 3;
              tot -= 2;
            end
          end
        end
        for (int k = 0; k < 16; k++) begin
          if (k >= p && k < h[c]) begin
            nxt[c][nh[c]] = col[c][k];
            nh[c]++;
          end
        end
      end
      col = nxt;
      h   = nh;
    end

    for (int c = 0; c < 16; c++) begin
      r0[c] = col[c][0];
      r1[c] = col[c][1];
    end
    return r0 + r1;
  endfunction

  state_e             state_q, state_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [IW-1:0]      i_q, i_d;
  logic [IW-1:0]      j_q, j_d;
  logic [15:0]        limb_prod;

  assign limb_prod = dadda_8x8(a_q[8*i_q +: 8], b_q[8*j_q +: 8]);

  always_comb begin
    // NOTE: every next-state signal defaults to its current value first, so
    // no path through the case below can leave one unassigned (no latches).
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    i_d     = i_q;
    j_d     = j_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          // A zero operand makes the product 0; skip the MUL sweep.
          state_d = (bus.in_a == '0 || bus.in_b == '0) ? S_DONE : S_MUL;
        end
      end

      S_MUL: begin
        acc_d = acc_q + (ACC_W'(limb_prod) << (8 * (int'(i_q) + int'(j_q))));
        // j is the inner index, i the outer.
        if (j_q == LAST) begin
          j_d = '0;
          if (i_q == LAST) state_d = S_DONE;
          else             i_d     = i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
      end

      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out_prod  = acc_q;

endmodule

// File: tb/tb_dadda_seq_mul.sv
// ---------------------------------------------------------------------------
// tb_dadda_seq_mul
//   Directed bench for dadda_seq_mul. Three instances (LIMBS = 2, 4, 1)
//   share clk/rst; 'sel' steers the common stimulus to one instance and
//   muxes that instance's outputs back for checking.
// ---------------------------------------------------------------------------
module tb_dadda_seq_mul;

  logic        clk = 1'b0;
  logic        rst;
  int          sel;
  logic        s_valid, s_ready;
  logic [63:0] s_a, s_b;

  logic        obs_in_ready, obs_out_valid, obs_busy;
  logic [63:0] obs_prod;

  int n_vec   = 0;
  int n_err   = 0;
  int cyc_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  dadda_seq_mul_if #(.LIMBS(2)) b2 ();
  dadda_seq_mul_if #(.LIMBS(4)) b4 ();
  dadda_seq_mul_if #(.LIMBS(1)) b1 ();

  dadda_seq_mul #(.LIMBS(2)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));
  dadda_seq_mul #(.LIMBS(4)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));
  dadda_seq_mul #(.LIMBS(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));

  assign b2.in_a      = s_a[15:0];
  assign b2.in_b      = s_b[15:0];
  assign b2.in_valid  = s_valid && (sel == 2);
  assign b2.out_ready = s_ready && (sel == 2);
  assign b4.in_a      = s_a[31:0];
  assign b4.in_b      = s_b[31:0];
  assign b4.in_valid  = s_valid && (sel == 4);
  assign b4.out_ready = s_ready && (sel == 4);
  assign b1.in_a      = s_a[7:0];
  assign b1.in_b      = s_b[7:0];
  assign b1.in_valid  = s_valid && (sel == 1);
  assign b1.out_ready = s_ready && (sel == 1);

  always_comb begin
    obs_in_ready  = b2.in_ready;
    obs_out_valid = b2.out_valid;
    obs_busy      = b2.busy;
    obs_prod      = 64'(b2.out_prod);
    if (sel == 4) begin
      obs_in_ready  = b4.in_ready;
      obs_out_valid = b4.out_valid;
      obs_busy      = b4.busy;
      obs_prod      = 64'(b4.out_prod);
    end else if (sel == 1) begin
      obs_in_ready  = b1.in_ready;
      obs_out_valid = b1.out_valid;
      obs_busy      = b1.busy;
      obs_prod      = 64'(b1.out_prod);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transaction. lat = clock edges from the accept edge until
  // out_valid is seen (0 means it is already high in the first cycle after
  // the accept edge). hold = cycles out_ready stays low once out_valid is up.
  task automatic do_op(input string tag, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp,
                       input int lat, input int hold);
    int cnt;
    s_a     = a;
    s_b     = b;
    s_valid = 1'b1;
    cnt     = 0;
    while (!obs_in_ready && cnt < 50) begin
      tick();
      cnt++;
    end
    check({tag, "_in_ready"}, 64'(obs_in_ready), 64'd1);
    tick();
    s_valid = 1'b0;
    cnt     = 0;
    while (!obs_out_valid && cnt < 100) begin
      tick();
      cnt++;
    end
    check({tag, "_latency"}, 64'(cnt), 64'(lat));
    check({tag, "_prod"}, obs_prod, exp);
    for (int k = 0; k < hold; k++) begin
      tick();
      check({tag, "_hold_valid"}, 64'(obs_out_valid), 64'd1);
      check({tag, "_hold_prod"}, obs_prod, exp);
      check({tag, "_hold_in_ready"}, 64'(obs_in_ready), 64'd0);
    end
    s_ready = 1'b1;
    tick();
    s_ready = 1'b0;
    check({tag, "_post_valid"}, 64'(obs_out_valid), 64'd0);
    check({tag, "_post_in_ready"}, 64'(obs_in_ready), 64'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          t_res [3];
    int          cnt;
    logic [63:0] ra, rb;
    logic [63:0] ones;

    rst     = 1'b1;
    sel     = 2;
    s_valid = 1'b0;
    s_ready = 1'b0;
    s_a     = '0;
    s_b     = '0;
    repeat (2) tick();
    rst = 1'b0;

    // Reset state
    check("rst_in_ready",  64'(obs_in_ready),  64'd1);
    check("rst_busy",      64'(obs_busy),      64'd0);
    check("rst_out_valid", 64'(obs_out_valid), 64'd0);
    check("rst_out_prod",  obs_prod,           64'd0);

    // 1: all-ones, 4-edge latency, busy throughout, in_valid while busy ignored
    s_a = 64'hFFFF; s_b = 64'hFFFF; s_valid = 1'b1;
    tick();
    s_a = 64'h1111; s_b = 64'h2222;
    for (int k = 0; k < 4; k++) begin
      check("t1_busy",    64'(obs_busy),      64'd1);
      check("t1_novalid", 64'(obs_out_valid), 64'd0);
      tick();
    end
    check("t1_valid", 64'(obs_out_valid), 64'd1);
    check("t1_prod",  obs_prod,           64'hFFFE0001);
    check("t1_busy_done", 64'(obs_busy),  64'd1);
    s_valid = 1'b0;
    s_ready = 1'b1;
    tick();
    s_ready = 1'b0;
    check("t1_post_valid",    64'(obs_out_valid), 64'd0);
    check("t1_post_in_ready", 64'(obs_in_ready),  64'd1);
    check("t1_post_busy",     64'(obs_busy),      64'd0);

    // 2: zero shortcut on either operand
    do_op("t2a", 64'h1234, 64'h0,    64'h0, 0, 0);
    do_op("t2b", 64'h0,    64'hFFFF, 64'h0, 0, 0);

    // 3: 10 cycles of backpressure
    do_op("t3", 64'h00FF, 64'h0100, 64'h0000FF00, 4, 10);

    // 4: reset in the 2nd MUL cycle discards the operation
    s_a = 64'hABCD; s_b = 64'h1234; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    check("t4_busy_mul", 64'(obs_busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_out_valid", 64'(obs_out_valid), 64'd0);
    check("t4_in_ready",  64'(obs_in_ready),  64'd1);
    check("t4_busy",      64'(obs_busy),      64'd0);
    do_op("t4b", 64'h3, 64'h5, 64'hF, 4, 0);

    // 5: streaming with in_valid/out_ready held high, one result per 6 cycles
    s_a = 64'h1; s_b = 64'h1; s_valid = 1'b1; s_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cnt = 0;
      do begin
        tick();
        cnt++;
      end while (!obs_out_valid && cnt < 50);
      t_res[k] = cyc_cnt;
      case (k)
        0: begin
          check("t5_r0", obs_prod, 64'h1);
          s_a = 64'h8000; s_b = 64'h2;
        end
        1: begin
          check("t5_r1", obs_prod, 64'h00010000);
          s_a = 64'hFFFF; s_b = 64'h1;
        end
        default: check("t5_r2", obs_prod, 64'h0000FFFF);
      endcase
    end
    s_valid = 1'b0;
    tick();
    s_ready = 1'b0;
    check("t5_gap01", 64'(t_res[1] - t_res[0]), 64'd6);
    check("t5_gap12", 64'(t_res[2] - t_res[1]), 64'd6);

    // 6: LIMBS=4 then LIMBS=1, corners then random pairs with backpressure
    for (int pass = 0; pass < 2; pass++) begin
      sel  = (pass == 0) ? 4 : 1;
      ones = (pass == 0) ? 64'hFFFF_FFFF : 64'hFF;
      do_op("t6_c00", 64'd0, 64'd0, 64'd0, 0, 1);
      do_op("t6_c11", 64'd1, 64'd1, 64'd1, sel * sel, 0);
      do_op("t6_cmm", ones, ones,
            (pass == 0) ? 64'hFFFF_FFFE_0000_0001 : 64'hFE01, sel * sel, 2);
      do_op("t6_cm1", ones, 64'd1, ones, sel * sel, 0);
      do_op("t6_c1m", 64'd1, ones, ones, sel * sel, 1);
      do_op("t6_c0m", 64'd0, ones, 64'd0, 0, 0);
      for (int n = 0; n < 1000; n++) begin
        ra = 64'($urandom) & ones;
        rb = 64'($urandom) & ones;
        do_op($sformatf("t6_L%0d_r%0d", sel, n), ra, rb, ra * rb,
              (ra == 0 || rb == 0) ? 0 : sel * sel, int'($urandom_range(0, 2)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
